ob_driver: RTL and testbench
============================

OB_DRIVER -- requirements
Module: ob_driver

Interface
REQ-001 SHALL have parameter OUTSTANDING_N, default cfg_pkg::OB_DRV_OUTSTANDING_N (4), giving the max in-flight commands.
REQ-002 SHALL have parameter LAT_W, default 16, giving the latency counter width.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 SHALL have port req_vld  in  1  host order request valid.
REQ-006 SHALL have port req  in  ob_pkg::drv_req_t  {opcode, quantity, price}.
REQ-007 SHALL have port req_accept  out  1  request taken this cycle.
REQ-008 SHALL have port cmd_vld_r  out  1  registered command strobe to order book.
REQ-009 SHALL have port cmd_r  out  ob_pkg::cmd_t  registered command {uid, opcode, oprand}.
REQ-010 SHALL have port cmd_full_r  in  1  order-book ingress full.
REQ-011 SHALL have port rsp_vld  in  1  order-book response valid.
REQ-012 SHALL have port rsp  in  ob_pkg::rsp_t  response, carries uid.
REQ-013 SHALL have port rsp_accept  out  1  response consumed.
REQ-014 SHALL have port cpl_vld_r  out  1  host completion valid.
REQ-015 SHALL have port cpl_r  out  ob_pkg::drv_cpl_t  {uid, status, latency[LAT_W]}.
REQ-016 SHALL have port cpl_accept  in  1  host takes completion.
REQ-017 SHALL have port drain  in  1  level; stop issuing, wait for all in-flight.
REQ-018 SHALL have port drain_done_r  out  1  drain complete.
REQ-019 SHALL have port inflight_r  out  $clog2(OUTSTANDING_N+1)  in-flight count.
REQ-020 SHALL have port err_uid_r  out  1  sticky: response with unknown uid.

Function
REQ-021 Issue condition: req_vld & state==RUN & free slot & ~cmd_full_r & ~cmd_vld_r & ~cpl_vld_r (for a bad opcode); issue happens on at most alternate cycles, covering the one-cycle lag of cmd_full_r.
REQ-022 On issue: req_accept=1; next cycle cmd_vld_r=1 for exactly one cycle; cmd_r.uid=uid_cnt; uid_cnt increments and wraps modulo 2^$bits(uid_t).
REQ-023 Issue SHALL allocate the lowest-index free scoreboard slot {vld, uid, age}; age starts at 0.
REQ-024 Only Op_Buy/Op_Sell SHALL be issued; any other opcode is accepted without a command and yields cpl_r.status=BadOp, latency 0, on the next cycle.
REQ-025 Each valid slot's age SHALL increment every cycle, saturating at 2^LAT_W-1.
REQ-026 rsp_accept = rsp_vld & (~cpl_vld_r | cpl_accept); a response with an unknown uid is always accepted and dropped.
REQ-027 On an accepted response matching a valid slot: free the slot; next cycle cpl_vld_r=1, uid=rsp.uid, status=Ok, latency=age+1.
REQ-028 On an accepted response with no match: set err_uid_r and issue no completion.
REQ-029 cpl_r SHALL hold stable while cpl_vld_r & ~cpl_accept.
REQ-030 A bad-opcode completion and a response completion SHALL never collide; REQ-021 blocks the request while the completion register is occupied.
REQ-031 Same-cycle issue and retire SHALL both take effect; inflight_r stays unchanged, and the freed slot becomes available next cycle.
REQ-032 FSM states RUN, DRAIN, IDLE:
  - RUN->DRAIN when drain=1.
  - DRAIN->IDLE when inflight_r==0 & ~cmd_vld_r & ~cpl_vld_r.
  - IDLE->RUN when drain=0.
  - drain_done_r=1 only in IDLE.
REQ-033 When all slots are valid, req_accept SHALL be 0.

Reset
REQ-034 While rst=0, and asynchronously: state=RUN, uid_cnt=0, all slots invalid, cmd_vld_r=0, cmd_r='0, cpl_vld_r=0, cpl_r='0, inflight_r=0, err_uid_r=0, drain_done_r=0.
REQ-035 Reset mid-operation SHALL discard in-flight tracking; late responses after reset set err_uid_r.
REQ-036 req_accept and rsp_accept SHALL be 0 during reset.

Structure
REQ-037 drv_req_t, drv_cpl_t and cpl_status_t {Ok, BadOp} SHALL live in ob_pkg; OB_DRV_OUTSTANDING_N SHALL live in cfg_pkg.
REQ-038 The scoreboard (alloc, CAM match, age, free) SHALL be the one sub-module, ob_drv_scoreboard.

Verification
REQ-039 Reset, then Buy qty=10 price=100 with cmd_full_r=0 -> cmd_vld_r one cycle later, uid=0; rsp uid=0 five cycles after issue -> cpl uid=0 Ok latency=5.
REQ-040 Issue 4 orders with no responses -> 5th request req_accept=0, inflight_r=4; one response -> 5th accepted.
REQ-041 cmd_full_r=1 for 10 cycles -> no cmd_vld_r; release -> issue resumes, with cmd_vld_r never on consecutive cycles.
REQ-042 rsp uid=7 with nothing outstanding -> rsp_accept=1, no cpl, err_uid_r=1 until reset.
REQ-043 Hold cpl_accept=0 with a pending rsp -> rsp_accept=0, cpl_r stable; cpl_accept=1 -> next rsp accepted the same cycle.
REQ-044 Two in-flight, drain=1 -> no issue; both responses -> drain_done_r=1; drain=0 -> RUN, uid continues at 2.

Source files
------------

// File: rtl/cfg_pkg.sv
// Build-time configuration shared by the order-book driver blocks.
package cfg_pkg;
  localparam int OB_DRV_OUTSTANDING_N = 4;
endpackage

// File: rtl/ob_pkg.sv
// Types exchanged between the host, the order-book driver and the order book.
package ob_pkg;
  localparam int UID_W     = 4;
  localparam int QTY_W     = 16;
  localparam int PRICE_W   = 16;
  localparam int OPRAND_W  = QTY_W + PRICE_W;
  // Width of the latency field carried to the host; ob_driver LAT_W must not exceed it.
  localparam int CPL_LAT_W = 16;

  typedef logic [UID_W-1:0] uid_t;

  typedef enum logic [2:0] {
    Op_Nop    = 3'd0,
    Op_Buy    = 3'd1,
    Op_Sell   = 3'd2,
    Op_Cancel = 3'd3,
    Op_Modify = 3'd4
  } opcode_t;

  typedef enum logic {
    Ok    = 1'b0,
    BadOp = 1'b1
  } cpl_status_t;

  typedef struct packed {
    opcode_t              opcode;
    logic [QTY_W-1:0]     quantity;
    logic [PRICE_W-1:0]   price;
  } drv_req_t;

  typedef struct packed {
    uid_t                 uid;
    opcode_t              opcode;
    logic [OPRAND_W-1:0]  oprand;
  } cmd_t;

  typedef struct packed {
    uid_t                 uid;
  } rsp_t;

  typedef struct packed {
    uid_t                 uid;
    cpl_status_t          status;
    logic [CPL_LAT_W-1:0] latency;
  } drv_cpl_t;

  function automatic logic is_issuable(input opcode_t op);
    return (op == Op_Buy) || (op == Op_Sell);
  endfunction
endpackage

// File: rtl/ob_drv_scoreboard.sv
// In-flight command tracker: lowest-free allocation, uid CAM lookup, per-slot
// saturating age, and release on retire.
module ob_drv_scoreboard
  import ob_pkg::*;
#(
  parameter int SLOTS_N = 4,
  parameter int LAT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  uid_t             alloc_uid,
  output logic             free_avail,
  input  uid_t             match_uid,
  output logic             match_hit,
  output logic [LAT_W-1:0] match_age,
  input  logic             retire
);

  logic             slot_vld [SLOTS_N];
  uid_t             slot_uid [SLOTS_N];
  logic [LAT_W-1:0] slot_age [SLOTS_N];
  logic [SLOTS_N-1:0] alloc_sel;
  logic [SLOTS_N-1:0] hit_sel;
  logic found_free;
  logic found_hit;

  always_comb begin
    alloc_sel  = '0;
    hit_sel    = '0;
    found_free = 1'b0;
    found_hit  = 1'b0;
    match_age  = '0;
    for (int i = 0; i < SLOTS_N; i++) begin
      if (!slot_vld[i] && !found_free) begin
        alloc_sel[i] = 1'b1;
        found_free   = 1'b1;
      end
      if (slot_vld[i] && (slot_uid[i] == match_uid) && !found_hit) begin
        hit_sel[i] = 1'b1;
        found_hit  = 1'b1;
        match_age  = slot_age[i];
      end
    end
  end

  assign free_avail = found_free;
  assign match_hit  = found_hit;

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS_N; gi++) begin : g_slot
      logic             vld_reg;
      uid_t             uid_reg;
      logic [LAT_W-1:0] age_reg;

      // An allocated slot was free and a retired slot was valid, so the two never coincide.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_reg <= 1'b0;
          uid_reg <= '0;
          age_reg <= '0;
        end else if (alloc && alloc_sel[gi]) begin
          vld_reg <= 1'b1;
          uid_reg <= alloc_uid;
          age_reg <= '0;
        end else begin
          if (retire && hit_sel[gi]) vld_reg <= 1'b0;
          if (vld_reg && (age_reg != '1)) age_reg <= age_reg + LAT_W'(1);
        end
      end

      assign slot_vld[gi] = vld_reg;
      assign slot_uid[gi] = uid_reg;
      assign slot_age[gi] = age_reg;
    end
  endgenerate

endmodule

// File: rtl/ob_driver.sv
// Host-side order-book driver: issues Buy/Sell commands with uids, matches
// responses back to measure latency, and supports a drain handshake.
module ob_driver
  import ob_pkg::*;
#(
  parameter int OUTSTANDING_N = cfg_pkg::OB_DRV_OUTSTANDING_N,
  parameter int LAT_W         = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_vld,
  input  drv_req_t                           req,
  output logic                               req_accept,
  output logic                               cmd_vld_r,
  output cmd_t                               cmd_r,
  input  logic                               cmd_full_r,
  input  logic                               rsp_vld,
  input  rsp_t                               rsp,
  output logic                               rsp_accept,
  output logic                               cpl_vld_r,
  output drv_cpl_t                           cpl_r,
  input  logic                               cpl_accept,
  input  logic                               drain,
  output logic                               drain_done_r,
  output logic [$clog2(OUTSTANDING_N+1)-1:0] inflight_r,
  output logic                               err_uid_r
);

  localparam int CNT_W = $clog2(OUTSTANDING_N + 1);

  typedef enum logic [1:0] {RUN, DRAIN, IDLE} drv_state_t;

  drv_state_t       state_reg;
  uid_t             uid_cnt_reg;
  logic             free_avail;
  logic             match_hit;
  logic [LAT_W-1:0] match_age;
  logic [LAT_W-1:0] lat_next;
  logic             can_take;
  logic             issue_go;
  logic             bad_go;
  logic             retire;

  // cmd_full_r lags by a cycle, so a command is never issued while the previous strobe is out.
  assign can_take = rst && req_vld && (state_reg == RUN) && free_avail &&
                    !cmd_full_r && !cmd_vld_r;
  assign issue_go = can_take && is_issuable(req.opcode);
  // A bad opcode needs the completion register; hold it off while a response may claim it.
  assign bad_go   = can_take && !is_issuable(req.opcode) && !cpl_vld_r && !rsp_vld;
  assign req_accept = issue_go || bad_go;

  assign rsp_accept = rst && rsp_vld && (!match_hit || !cpl_vld_r || cpl_accept);
  assign retire     = rsp_accept && match_hit;
  assign lat_next   = (match_age == '1) ? match_age : match_age + LAT_W'(1);

  ob_drv_scoreboard #(
    .SLOTS_N (OUTSTANDING_N),
    .LAT_W   (LAT_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .alloc      (issue_go),
    .alloc_uid  (uid_cnt_reg),
    .free_avail (free_avail),
    .match_uid  (rsp.uid),
    .match_hit  (match_hit),
    .match_age  (match_age),
    .retire     (retire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uid_cnt_reg <= '0;
      cmd_vld_r   <= 1'b0;
      cmd_r       <= '0;
      cpl_vld_r   <= 1'b0;
      cpl_r       <= '0;
      err_uid_r   <= 1'b0;
      inflight_r  <= '0;
    end else begin
      if (req_accept) uid_cnt_reg <= uid_cnt_reg + UID_W'(1);

      cmd_vld_r <= issue_go;
      if (issue_go) begin
        cmd_r.uid    <= uid_cnt_reg;
        cmd_r.opcode <= req.opcode;
        cmd_r.oprand <= {req.quantity, req.price};
      end

      if (retire) begin
        cpl_vld_r     <= 1'b1;
        cpl_r.uid     <= rsp.uid;
        cpl_r.status  <= Ok;
        cpl_r.latency <= CPL_LAT_W'(lat_next);
      end else if (bad_go) begin
        cpl_vld_r     <= 1'b1;
        cpl_r.uid     <= uid_cnt_reg;
        cpl_r.status  <= BadOp;
        cpl_r.latency <= '0;
      end else if (cpl_accept) begin
        cpl_vld_r <= 1'b0;
      end

      if (rsp_accept && !match_hit) err_uid_r <= 1'b1;

      case ({issue_go, retire})
        2'b10:   inflight_r <= inflight_r + CNT_W'(1);
        2'b01:   inflight_r <= inflight_r - CNT_W'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= RUN;
      drain_done_r <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (drain) state_reg <= DRAIN;
        end
        DRAIN: begin
          if ((inflight_r == '0) && !cmd_vld_r && !cpl_vld_r) begin
            state_reg    <= IDLE;
            drain_done_r <= 1'b1;
          end
        end
        IDLE: begin
          if (!drain) begin
            state_reg    <= RUN;
            drain_done_r <= 1'b0;
          end
        end
        default: begin
          state_reg    <= RUN;
          drain_done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ob_driver.sv
// Directed bench for ob_driver: a cycle-by-cycle vector table plus hand-written
// sequences for reset, back-pressure, capacity, unknown uids and drain.
module tb_ob_driver;
  import ob_pkg::*;

  localparam int OUT_N = 4;
  localparam int LAT_W = 16;
  localparam int CNT_W = $clog2(OUT_N + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_vld;
  drv_req_t         req;
  logic             req_accept;
  logic             cmd_vld_r;
  cmd_t             cmd_r;
  logic             cmd_full_r;
  logic             rsp_vld;
  rsp_t             rsp;
  logic             rsp_accept;
  logic             cpl_vld_r;
  drv_cpl_t         cpl_r;
  logic             cpl_accept;
  logic             drain;
  logic             drain_done_r;
  logic [CNT_W-1:0] inflight_r;
  logic             err_uid_r;

  int n_checks = 0;
  int n_fail   = 0;

  ob_driver #(.OUTSTANDING_N(OUT_N), .LAT_W(LAT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_vld      (req_vld),
    .req          (req),
    .req_accept   (req_accept),
    .cmd_vld_r    (cmd_vld_r),
    .cmd_r        (cmd_r),
    .cmd_full_r   (cmd_full_r),
    .rsp_vld      (rsp_vld),
    .rsp          (rsp),
    .rsp_accept   (rsp_accept),
    .cpl_vld_r    (cpl_vld_r),
    .cpl_r        (cpl_r),
    .cpl_accept   (cpl_accept),
    .drain        (drain),
    .drain_done_r (drain_done_r),
    .inflight_r   (inflight_r),
    .err_uid_r    (err_uid_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             req_vld;
    opcode_t          op;
    logic             full;
    logic             rsp_vld;
    uid_t             rsp_uid;
    logic             cpl_acc;
    logic             e_req_acc;
    logic             e_rsp_acc;
    logic             e_cmd_vld;
    uid_t             e_cmd_uid;
    logic             e_cpl_vld;
    uid_t             e_cpl_uid;
    cpl_status_t      e_st;
    logic [15:0]      e_lat;
    logic [CNT_W-1:0] e_infl;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input int rv, input opcode_t op, input int full, input int sv,
                              input int suid, input int cacc, input int ra, input int sa,
                              input int cv, input int cuid, input int pv, input int puid,
                              input cpl_status_t st, input int lat, input int infl);
    vec_t v;
    v.req_vld   = 1'(rv);
    v.op        = op;
    v.full      = 1'(full);
    v.rsp_vld   = 1'(sv);
    v.rsp_uid   = UID_W'(suid);
    v.cpl_acc   = 1'(cacc);
    v.e_req_acc = 1'(ra);
    v.e_rsp_acc = 1'(sa);
    v.e_cmd_vld = 1'(cv);
    v.e_cmd_uid = UID_W'(cuid);
    v.e_cpl_vld = 1'(pv);
    v.e_cpl_uid = UID_W'(puid);
    v.e_st      = st;
    v.e_lat     = 16'(lat);
    v.e_infl    = CNT_W'(infl);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_vld    = 1'b0;
    req        = '{opcode: Op_Nop, quantity: 16'd0, price: 16'd0};
    cmd_full_r = 1'b0;
    rsp_vld    = 1'b0;
    rsp.uid    = '0;
    cpl_accept = 1'b1;
    drain      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    req_vld = 1'b1;
    req     = '{opcode: Op_Buy, quantity: 16'd1, price: 16'd1};
    rsp_vld = 1'b1;
    rsp.uid = UID_W'(1);
    rst     = 1'b0;
    #2;
    check("rst_req_accept", req_accept, 0);
    check("rst_rsp_accept", rsp_accept, 0);
    check("rst_cmd_vld", cmd_vld_r, 0);
    check("rst_cpl_vld", cpl_vld_r, 0);
    check("rst_inflight", inflight_r, 0);
    check("rst_err_uid", err_uid_r, 0);
    check("rst_drain_done", drain_done_r, 0);
    tick();
    idle_inputs();
    rst = 1'b1;
    #1;
  endtask

  task automatic issue_one(input opcode_t op);
    logic ok;
    ok      = 1'b0;
    req_vld = 1'b1;
    req     = '{opcode: op, quantity: 16'd5, price: 16'd50};
    for (int k = 0; k < 10 && !ok; k++) begin
      #1;
      if (req_accept) ok = 1'b1;
      tick();
    end
    req_vld = 1'b0;
    check("issue_accepted", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int strobes;
    int consec;
    logic prev;
    drv_cpl_t held;

    //            rv op         fl sv su ca  ra sa cv cu pv pu st     lat in
    vecs[0]  = mk(1, Op_Buy,    0, 0, 0, 1,  1, 0, 1, 0, 0, 0, Ok,    0,  1);
    vecs[1]  = mk(1, Op_Sell,   0, 0, 0, 1,  0, 0, 0, 0, 0, 0, Ok,    0,  1);
    vecs[2]  = mk(1, Op_Sell,   0, 0, 0, 1,  1, 0, 1, 1, 0, 0, Ok,    0,  2);
    vecs[3]  = mk(0, Op_Nop,    0, 1, 0, 1,  0, 1, 0, 0, 1, 0, Ok,    3,  1);
    vecs[4]  = mk(1, Op_Cancel, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, Ok,    0,  1);
    vecs[5]  = mk(1, Op_Cancel, 0, 0, 0, 1,  1, 0, 0, 0, 1, 2, BadOp, 0,  1);
    vecs[6]  = mk(1, Op_Buy,    1, 0, 0, 1,  0, 0, 0, 0, 0, 0, Ok,    0,  1);
    vecs[7]  = mk(1, Op_Buy,    0, 0, 0, 1,  1, 0, 1, 3, 0, 0, Ok,    0,  2);
    vecs[8]  = mk(1, Op_Buy,    0, 1, 1, 1,  0, 1, 0, 0, 1, 1, Ok,    6,  1);
    vecs[9]  = mk(1, Op_Buy,    0, 1, 3, 1,  1, 1, 1, 4, 1, 3, Ok,    2,  1);
    vecs[10] = mk(0, Op_Nop,    0, 1, 9, 1,  0, 1, 0, 0, 0, 0, Ok,    0,  1);

    idle_inputs();
    do_reset();

    for (int i = 0; i < 11; i++) begin
      req_vld    = vecs[i].req_vld;
      req        = '{opcode: vecs[i].op, quantity: 16'(i + 1), price: 16'(100 + i)};
      cmd_full_r = vecs[i].full;
      rsp_vld    = vecs[i].rsp_vld;
      rsp.uid    = vecs[i].rsp_uid;
      cpl_accept = vecs[i].cpl_acc;
      #1;
      check($sformatf("v%0d_req_accept", i), req_accept, vecs[i].e_req_acc);
      check($sformatf("v%0d_rsp_accept", i), rsp_accept, vecs[i].e_rsp_acc);
      tick();
      check($sformatf("v%0d_cmd_vld", i), cmd_vld_r, vecs[i].e_cmd_vld);
      if (vecs[i].e_cmd_vld) check($sformatf("v%0d_cmd_uid", i), cmd_r.uid, vecs[i].e_cmd_uid);
      check($sformatf("v%0d_cpl_vld", i), cpl_vld_r, vecs[i].e_cpl_vld);
      if (vecs[i].e_cpl_vld) begin
        check($sformatf("v%0d_cpl_uid", i), cpl_r.uid, vecs[i].e_cpl_uid);
        check($sformatf("v%0d_cpl_status", i), cpl_r.status, vecs[i].e_st);
        check($sformatf("v%0d_cpl_latency", i), cpl_r.latency, vecs[i].e_lat);
      end
      check($sformatf("v%0d_inflight", i), inflight_r, vecs[i].e_infl);
    end
    idle_inputs();
    check("table_err_uid", err_uid_r, 1);

    // Single Buy round trip with a five-cycle response.
    do_reset();
    req_vld = 1'b1;
    req     = '{opcode: Op_Buy, quantity: 16'd10, price: 16'd100};
    #1;
    check("rt_req_accept", req_accept, 1);
    tick();
    req_vld = 1'b0;
    check("rt_cmd_vld", cmd_vld_r, 1);
    check("rt_cmd_uid", cmd_r.uid, 0);
    check("rt_cmd_opcode", cmd_r.opcode, Op_Buy);
    check("rt_cmd_oprand", cmd_r.oprand, {16'd10, 16'd100});
    tick();
    check("rt_cmd_one_cycle", cmd_vld_r, 0);
    tick();
    tick();
    tick();
    rsp_vld = 1'b1;
    rsp.uid = '0;
    #1;
    check("rt_rsp_accept", rsp_accept, 1);
    tick();
    rsp_vld = 1'b0;
    check("rt_cpl_vld", cpl_vld_r, 1);
    check("rt_cpl_uid", cpl_r.uid, 0);
    check("rt_cpl_status", cpl_r.status, Ok);
    check("rt_cpl_latency", cpl_r.latency, 5);

    // Capacity: four outstanding blocks the fifth until a slot frees.
    do_reset();
    for (int k = 0; k < 4; k++) issue_one(Op_Buy);
    check("cap_inflight4", inflight_r, 4);
    req_vld = 1'b1;
    req     = '{opcode: Op_Sell, quantity: 16'd7, price: 16'd70};
    for (int k = 0; k < 3; k++) begin
      #1;
      check("cap_full_block", req_accept, 0);
      tick();
    end
    rsp_vld = 1'b1;
    rsp.uid = '0;
    #1;
    check("cap_rsp_accept", rsp_accept, 1);
    check("cap_same_cycle_block", req_accept, 0);
    tick();
    rsp_vld = 1'b0;
    #1;
    check("cap_fifth_accept", req_accept, 1);
    tick();
    req_vld = 1'b0;
    check("cap_fifth_cmd_vld", cmd_vld_r, 1);
    check("cap_fifth_uid", cmd_r.uid, 4);
    check("cap_inflight_after", inflight_r, 4);

    // Back-pressure from the order book, then alternate-cycle issue.
    do_reset();
    cmd_full_r = 1'b1;
    req_vld    = 1'b1;
    req        = '{opcode: Op_Buy, quantity: 16'd2, price: 16'd20};
    strobes    = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (cmd_vld_r) strobes++;
    end
    check("full_no_cmd", strobes, 0);
    cmd_full_r = 1'b0;
    strobes    = 0;
    consec     = 0;
    prev       = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (cmd_vld_r) strobes++;
      if (cmd_vld_r && prev) consec++;
      prev = cmd_vld_r;
    end
    req_vld = 1'b0;
    check("release_cmd_count", strobes, 4);
    check("release_no_back_to_back", consec, 0);

    // Unknown uid with nothing outstanding.
    do_reset();
    rsp_vld = 1'b1;
    rsp.uid = UID_W'(7);
    #1;
    check("unk_rsp_accept", rsp_accept, 1);
    tick();
    rsp_vld = 1'b0;
    check("unk_no_cpl", cpl_vld_r, 0);
    check("unk_err_set", err_uid_r, 1);
    tick();
    tick();
    tick();
    check("unk_err_sticky", err_uid_r, 1);

    // Completion back-pressure holds the response and the completion.
    do_reset();
    cpl_accept = 1'b0;
    issue_one(Op_Buy);
    issue_one(Op_Sell);
    rsp_vld = 1'b1;
    rsp.uid = '0;
    #1;
    check("bp_first_rsp_accept", rsp_accept, 1);
    tick();
    check("bp_cpl_vld", cpl_vld_r, 1);
    check("bp_cpl_uid0", cpl_r.uid, 0);
    held    = cpl_r;
    rsp.uid = UID_W'(1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_rsp_blocked", rsp_accept, 0);
      tick();
      check("bp_cpl_stable", cpl_r, held);
    end
    cpl_accept = 1'b1;
    #1;
    check("bp_rsp_same_cycle", rsp_accept, 1);
    tick();
    rsp_vld = 1'b0;
    check("bp_cpl_vld_next", cpl_vld_r, 1);
    check("bp_cpl_uid1", cpl_r.uid, 1);
    tick();
    check("bp_cpl_cleared", cpl_vld_r, 0);

    // Drain with two outstanding, then resume.
    do_reset();
    issue_one(Op_Buy);
    issue_one(Op_Buy);
    drain   = 1'b1;
    req_vld = 1'b1;
    req     = '{opcode: Op_Buy, quantity: 16'd3, price: 16'd30};
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("drain_no_issue", req_accept, 0);
      check("drain_not_done", drain_done_r, 0);
      tick();
    end
    rsp_vld = 1'b1;
    rsp.uid = '0;
    tick();
    rsp.uid = UID_W'(1);
    tick();
    rsp_vld = 1'b0;
    for (int k = 0; k < 10 && !drain_done_r; k++) tick();
    check("drain_done", drain_done_r, 1);
    check("drain_inflight0", inflight_r, 0);
    drain = 1'b0;
    tick();
    check("resume_done_clear", drain_done_r, 0);
    #1;
    check("resume_accept", req_accept, 1);
    tick();
    req_vld = 1'b0;
    check("resume_cmd_vld", cmd_vld_r, 1);
    check("resume_uid2", cmd_r.uid, 2);

    // Reset with a command in flight; its late response is unknown.
    do_reset();
    rsp_vld = 1'b1;
    rsp.uid = UID_W'(2);
    #1;
    check("late_rsp_accept", rsp_accept, 1);
    tick();
    rsp_vld = 1'b0;
    check("late_err_uid", err_uid_r, 1);
    check("late_no_cpl", cpl_vld_r, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
